cp0: RTL and testbench

//  Coprocessor-0 for the P8 pipeline: holds SR(12), Cause(13), EPC(14), PRId(15).

---
 rtl/cp0_pkg.sv | 50 +++++
 rtl/cp0_if.sv | 37 +++
 rtl/cp0_exc_arb.sv | 32 +++
 rtl/cp0.sv | 103 ++++++++++
 tb/tb_cp0.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// ----------------------------------------------------------------------------
// cp0_defs: shared definitions for the P8 coprocessor-0 slice.
//   - CP0 register indices (SR, Cause, EPC, PRId)
//   - exception codes written into Cause.ExcCode
//   - field bit positions inside SR and Cause
//   - helper that computes the EPC value for a victim instruction
// No ports; imported by cp0_if, cp0_exc_arb and cp0.
// ----------------------------------------------------------------------------
package cp0_defs;

    // Register indices as seen by mfc0/mtc0
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Exception codes
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    // Number of hardware interrupt lines (fixed by the IM/IP field width)
    localparam int HWINT_W = 6;

    // Field positions
    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LO      = 10;
    localparam int SR_IM_HI      = 15;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IP_LO   = 10;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_BD_BIT  = 31;

    // Handler entry point the PC redirects to when Req is raised
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    // EPC for a victim: a delay-slot victim restarts at its branch (VPC-4).
    // Arithmetic wraps mod 2^32; the low two bits are always cleared.
    function automatic logic [31:0] epc_target(input logic [31:0] vpc, input logic bd);
        logic [31:0] pc;
        pc = bd ? (vpc - 32'd4) : vpc;
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_if.sv
// ----------------------------------------------------------------------------
// cp0_if: bundle between the P8 pipeline (master) and coprocessor 0 (slave).
//   A1        mfc0 read index          A2        mtc0 write index
//   Din       mtc0 write data          WE        mtc0 write enable
//   VPC       victim PC (M stage)      BDIn      victim in a delay slot
//   ExcCodeIn M-stage exception code   HWInt     interrupt lines (level)
//   EXLClr    eret in M stage
//   Dout      mfc0 read data           EPCOut    current EPC
//   Req       exception/interrupt request
// ----------------------------------------------------------------------------
interface cp0_if;
    import cp0_defs::*;

    logic [4:0]         A1;
    logic [4:0]         A2;
    logic [31:0]        Din;
    logic               WE;
    logic [31:0]        VPC;
    logic               BDIn;
    logic [4:0]         ExcCodeIn;
    logic [HWINT_W-1:0] HWInt;
    logic               EXLClr;
    logic [31:0]        Dout;
    logic [31:0]        EPCOut;
    logic               Req;

    modport master (
        output A1, A2, Din, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  Dout, EPCOut, Req
    );

    modport slave (
        input  A1, A2, Din, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output Dout, EPCOut, Req
    );

endinterface

// File: rtl/cp0_exc_arb.sv
// ----------------------------------------------------------------------------
// cp0_exc_arb: combinational arbitration of hardware interrupts against the
// synchronous M-stage exception.
//   hwint, im     interrupt lines and mask      ie, exl   SR enable bits
//   exc_code_in   M-stage exception code (0 = none)
//   int_req       unmasked interrupt pending    exc_req   exception pending
//   req           either of the above
//   exc_code_nxt  code to latch into Cause.ExcCode when req is taken
// ----------------------------------------------------------------------------
module cp0_exc_arb
    import cp0_defs::*;
(
    input  logic [HWINT_W-1:0] hwint,
    input  logic [HWINT_W-1:0] im,
    input  logic               ie,
    input  logic               exl,
    input  logic [4:0]         exc_code_in,
    output logic               int_req,
    output logic               exc_req,
    output logic               req,
    output logic [4:0]         exc_code_nxt
);

    // EXL blocks both sources, so a request raised inside a handler is lost
    // until eret clears EXL.
    assign int_req      = (|(hwint & im)) & ie & ~exl;
    assign exc_req      = (exc_code_in != 5'd0) & ~exl;
    assign req          = int_req | exc_req;
    // Interrupts win over a simultaneous exception.
    assign exc_code_nxt = int_req ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0.sv
// ----------------------------------------------------------------------------
// cp0: coprocessor 0 for the P8 pipeline. Holds SR(12), Cause(13), EPC(14)
// and the read-only PRId(15); raises Req combinationally so the PC can
// redirect to the handler in the same cycle.
//   clk    clock, all state on posedge
//   reset  synchronous, active-low
//   bus    cp0_if.slave (see cp0_if for the signal list)
// ----------------------------------------------------------------------------
module cp0
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID    = 32'h2023_0913,
    parameter int          HWINT_W = 6
) (
    input  logic   clk,
    input  logic   reset,
    cp0_if.slave   bus
);

    // SR fields
    logic [HWINT_W-1:0] im_q;
    logic               exl_q;
    logic               ie_q;
    // Cause fields
    logic               bd_q;
    logic [HWINT_W-1:0] ip_q;
    logic [4:0]         exc_code_q;
    // EPC
    logic [31:0]        epc_q;

    logic               int_req;
    logic               exc_req;
    logic               req;
    logic [4:0]         exc_code_nxt;
    logic               we_sr;
    logic               we_epc;

    cp0_exc_arb u_arb (
        .hwint        (bus.HWInt),
        .im           (im_q),
        .ie           (ie_q),
        .exl          (exl_q),
        .exc_code_in  (bus.ExcCodeIn),
        .int_req      (int_req),
        .exc_req      (exc_req),
        .req          (req),
        .exc_code_nxt (exc_code_nxt)
    );

    // Cause and PRId are read-only to software, so only SR and EPC decode.
    assign we_sr  = bus.WE && (bus.A2 == REG_SR);
    assign we_epc = bus.WE && (bus.A2 == REG_EPC);

    always_ff @(posedge clk) begin
        if (!reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            ip_q <= bus.HWInt;
            if (req) begin
                // The victim is cancelled, so any mtc0 it carries is dropped,
                // and an eret in flight cannot clear the EXL being set here.
                exl_q      <= 1'b1;
                exc_code_q <= exc_code_nxt;
                bd_q       <= bus.BDIn;
                epc_q      <= epc_target(bus.VPC, bus.BDIn);
            end else begin
                if (we_sr) begin
                    im_q  <= bus.Din[SR_IM_HI:SR_IM_LO];
                    ie_q  <= bus.Din[SR_IE_BIT];
                    // An eret alongside the write still leaves EXL clear.
                    exl_q <= bus.Din[SR_EXL_BIT] & ~bus.EXLClr;
                end else if (bus.EXLClr) begin
                    exl_q <= 1'b0;
                end
                if (we_epc) begin
                    epc_q <= bus.Din;
                end
            end
        end
    end

    // mfc0 read port: no bypass of a same-cycle mtc0.
    always_comb begin
        bus.Dout = 32'd0;
        unique case (bus.A1)
            REG_SR:    bus.Dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
            REG_CAUSE: bus.Dout = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
            REG_EPC:   bus.Dout = epc_q;
            REG_PRID:  bus.Dout = PRID;
            default:   bus.Dout = 32'd0;
        endcase
    end

    assign bus.EPCOut = epc_q;
    assign bus.Req    = req;

endmodule

// File: tb/tb_cp0.sv
// ----------------------------------------------------------------------------
// tb_cp0: directed bench for cp0. The stimulus process drives one cycle at a
// time and queues the values it expects to observe in that cycle; a monitor
// on the falling edge pops and compares them against the DUT outputs.
// ----------------------------------------------------------------------------
module tb_cp0;
    import cp0_defs::*;

    localparam logic [31:0] PRID_V = 32'h2023_0913;

    typedef struct {
        int          cyc;
        int          kind;   // 0 = Dout, 1 = Req, 2 = EPCOut
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fails;
    exp_t sb[$];

    cp0_if bus();

    cp0 #(.PRID(PRID_V), .HWINT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every entry queued for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                0:       act = bus.Dout;
                1:       act = {31'd0, bus.Req};
                default: act = bus.EPCOut;
            endcase
            n_checks++;
            if (e.cyc != cyc || act !== e.exp) begin
                n_fails++;
                $display("FAIL %s: got %h expected %h (cycle %0d, queued %0d)",
                         e.name, act, e.exp, cyc, e.cyc);
            end
        end
    end

    task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [4:0] idx, input logic [31:0] exp, input string name);
        bus.A1 = idx;
        expect_val(0, exp, name);
    endtask

    // Start a new cycle just after the rising edge with pulse inputs idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        reset         = 1'b1;
        bus.WE        = 1'b0;
        bus.A2        = 5'd0;
        bus.Din       = 32'd0;
        bus.ExcCodeIn = 5'd0;
        bus.BDIn      = 1'b0;
        bus.EXLClr    = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        reset         = 1'b0;
        bus.A1        = 5'd0;
        bus.A2        = 5'd0;
        bus.Din       = 32'd0;
        bus.WE        = 1'b0;
        bus.VPC       = 32'd0;
        bus.BDIn      = 1'b0;
        bus.ExcCodeIn = 5'd0;
        bus.HWInt     = 6'h00;
        bus.EXLClr    = 1'b0;

        // Reset state
        next_cycle(); rd(REG_SR, 32'd0, "rst_sr"); expect_val(1, 0, "rst_req");
        next_cycle(); rd(REG_CAUSE, 32'd0, "rst_cause");
        next_cycle(); rd(REG_EPC, 32'd0, "rst_epc"); expect_val(2, 0, "rst_epcout");
        next_cycle(); bus.HWInt = 6'h3F; rd(REG_PRID, PRID_V, "prid"); expect_val(1, 0, "rst_req_hw");
        next_cycle(); rd(5'd3, 32'd0, "unmapped_idx");

        // Unmasked interrupt
        next_cycle(); bus.WE = 1'b1; bus.A2 = REG_SR; bus.Din = 32'h0000_0401;
        expect_val(1, 0, "req_before_ie");
        next_cycle(); bus.HWInt = 6'h01; bus.VPC = 32'h3010;
        rd(REG_SR, 32'h0000_0401, "sr_written"); expect_val(1, 1, "int_req");
        next_cycle(); rd(REG_EPC, 32'h3010, "int_epc"); expect_val(1, 0, "int_req_exl");
        expect_val(2, 32'h3010, "int_epcout");
        next_cycle(); rd(REG_CAUSE, 32'h0000_0400, "int_cause");
        next_cycle(); rd(REG_SR, 32'h0000_0403, "int_sr_exl");

        // eret clears EXL
        next_cycle(); bus.EXLClr = 1'b1; bus.HWInt = 6'h00;
        next_cycle(); rd(REG_SR, 32'h0000_0401, "eret_sr"); expect_val(1, 0, "eret_req");

        // Overflow in a delay slot
        next_cycle(); bus.ExcCodeIn = EXC_OV; bus.BDIn = 1'b1; bus.VPC = 32'h3024;
        expect_val(1, 1, "ov_req");
        next_cycle(); rd(REG_CAUSE, 32'h8000_0030, "ov_cause"); expect_val(2, 32'h3020, "ov_epcout");

        // Nested exception while EXL=1 is ignored
        next_cycle(); bus.ExcCodeIn = EXC_ADEL; bus.VPC = 32'h5000; expect_val(1, 0, "nested_req");
        next_cycle(); rd(REG_EPC, 32'h3020, "nested_epc");
        next_cycle(); rd(REG_CAUSE, 32'h8000_0030, "nested_cause");
        next_cycle(); bus.EXLClr = 1'b1;

        // Interrupt beats a simultaneous exception
        next_cycle(); bus.HWInt = 6'h01; bus.ExcCodeIn = EXC_RI; bus.VPC = 32'h4000;
        expect_val(1, 1, "prio_req");
        next_cycle(); bus.EXLClr = 1'b1; bus.HWInt = 6'h00;
        rd(REG_CAUSE, 32'h0000_0400, "prio_cause");
        // Same with an mtc0 EPC that must be dropped; VPC low bits get cleared
        next_cycle(); bus.HWInt = 6'h01; bus.ExcCodeIn = EXC_RI; bus.VPC = 32'h4103;
        bus.WE = 1'b1; bus.A2 = REG_EPC; bus.Din = 32'd5;
        expect_val(1, 1, "drop_req");
        next_cycle(); bus.HWInt = 6'h00; rd(REG_EPC, 32'h4100, "drop_epc");
        expect_val(2, 32'h4100, "drop_epcout");
        next_cycle(); rd(REG_CAUSE, 32'h0000_0000, "drop_cause");

        // eret and a new request in the same cycle: EXL stays set
        next_cycle(); bus.EXLClr = 1'b1;
        next_cycle(); bus.EXLClr = 1'b1; bus.ExcCodeIn = EXC_SYSCALL; bus.VPC = 32'h4200;
        expect_val(1, 1, "clr_req");
        next_cycle(); rd(REG_SR, 32'h0000_0403, "clr_req_sr"); expect_val(1, 0, "clr_req_after");

        // mtc0 SR together with eret: value written, EXL cleared, junk bits dropped
        next_cycle(); bus.WE = 1'b1; bus.A2 = REG_SR; bus.Din = 32'hFFFF_FC03; bus.EXLClr = 1'b1;
        next_cycle(); rd(REG_SR, 32'h0000_FC01, "sr_we_clr");

        // EPC wrap-around for a delay-slot victim at address 0
        next_cycle(); bus.ExcCodeIn = EXC_ADES; bus.BDIn = 1'b1; bus.VPC = 32'h0;
        expect_val(1, 1, "wrap_req");
        next_cycle(); rd(REG_EPC, 32'hFFFF_FFFC, "wrap_epc");
        next_cycle(); rd(REG_CAUSE, 32'h8000_0014, "wrap_cause");

        // Reset in the middle of a handler
        next_cycle(); reset = 1'b0;
        next_cycle(); bus.HWInt = 6'h3F; rd(REG_SR, 32'd0, "mid_rst_sr"); expect_val(1, 0, "mid_rst_req");
        next_cycle(); bus.WE = 1'b1; bus.A2 = REG_CAUSE; bus.Din = 32'hFFFF_FFFF;
        rd(REG_EPC, 32'd0, "mid_rst_epc");
        next_cycle(); rd(REG_CAUSE, 32'h0000_FC00, "cause_ro");

        // PRId is read-only; plain mtc0 EPC lands
        next_cycle(); bus.WE = 1'b1; bus.A2 = REG_PRID; bus.Din = 32'd0;
        next_cycle(); rd(REG_PRID, PRID_V, "prid_ro");
        bus.WE = 1'b1; bus.A2 = REG_EPC; bus.Din = 32'h1234_5670;
        next_cycle(); rd(REG_EPC, 32'h1234_5670, "mtc0_epc"); expect_val(2, 32'h1234_5670, "mtc0_epcout");

        // Drain: every queued expectation must have been consumed
        next_cycle();
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
